// File: rtl/rst_release_seq_if.sv
// Handshake bundle of the reset-release sequencer: the START request plus
// the per-group reset and clock-enable outputs and the BUSY/DONE status.
interface rst_release_seq_if #(
  parameter int NGRP = 4
);
  logic            start;
  logic [NGRP-1:0] rn_out;
  logic [NGRP-1:0] cken;
  logic            busy;
  logic            done;

  modport master (output start, input rn_out, cken, busy, done);
  modport slave  (input start, output rn_out, cken, busy, done);
endinterface

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: gate clocks, hold reset for a minimum width, then
// release groups and ungate after a margin. RST_SEQ_STAGGER_EN staggers the release.
module rst_release_seq #(
  parameter int NGRP      = 4,
  parameter int WAIT_CYC  = 3,
  parameter int PULSE_CYC = 2,
  parameter int STAGGER   = 2
) (
  input  logic             ck,
  input  logic             rst,
  rst_release_seq_if.slave bus
);

`ifdef RST_SEQ_STAGGER_EN
  localparam int REL_LEN = (NGRP - 1) * STAGGER + 1;
`else
  localparam int REL_LEN = 1;
`endif
  localparam int MAX_WP = (WAIT_CYC > PULSE_CYC) ? WAIT_CYC : PULSE_CYC;
  localparam int MAX_D  = (MAX_WP > REL_LEN) ? MAX_WP : REL_LEN;
  localparam int CW     = $clog2(MAX_D + 1);
  localparam int IW     = (NGRP > 1) ? $clog2(NGRP + 1) : 1;

  localparam logic [CW-1:0]   WAIT_LD  = CW'(WAIT_CYC);
  localparam logic [CW-1:0]   PULSE_LD = CW'(PULSE_CYC);
  localparam logic [CW-1:0]   REL_LD   = CW'(REL_LEN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1'b1);
  localparam logic [NGRP-1:0] ONE_GRP  = NGRP'(1'b1);
`ifdef RST_SEQ_STAGGER_EN
  localparam logic [NGRP-1:0] REL_FIRST = ONE_GRP;
`else
  localparam logic [NGRP-1:0] REL_FIRST = {NGRP{1'b1}};
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GATE    = 3'd1,
    ASSERT  = 3'd2,
    RELEASE = 3'd3,
    SETTLE  = 3'd4,
    UNGATE  = 3'd5
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [IW-1:0]   idx_r;
  logic [NGRP-1:0] rn_out_r;
  logic [NGRP-1:0] cken_r;
  logic            busy_r;
  logic            done_r;
  logic            hit_s;
  logic [NGRP-1:0] grp_bit_s;

  // Group idx_r is due when the cycle after this edge sits idx_r*STAGGER past RELEASE entry
  always_comb begin
    hit_s     = 1'b0;
    grp_bit_s = ONE_GRP << idx_r;
    if ((int'(idx_r) < NGRP) &&
        ((REL_LEN - int'(cnt_r) + 1) == (int'(idx_r) * STAGGER))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Sequencer FSM; cnt_r holds the cycles left in the current state, including this one
  always_ff @(posedge ck) begin
    if (rst) begin
      state_r  <= ASSERT;
      cnt_r    <= PULSE_LD;
      idx_r    <= '0;
      rn_out_r <= '0;
      cken_r   <= '0;
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= GATE;
            cnt_r   <= WAIT_LD;
            cken_r  <= '0;
            busy_r  <= 1'b1;
          end else begin
            rn_out_r <= '1;
            cken_r   <= '1;
            busy_r   <= 1'b0;
          end
        end
        GATE: begin
          if (cnt_r == CNT_ONE) begin
            state_r  <= ASSERT;
            cnt_r    <= PULSE_LD;
            rn_out_r <= '0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ASSERT: begin
          if (cnt_r == CNT_ONE) begin
            state_r  <= RELEASE;
            cnt_r    <= REL_LD;
            rn_out_r <= REL_FIRST;
            idx_r    <= IDX_ONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RELEASE: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= SETTLE;
            cnt_r   <= WAIT_LD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
            if (hit_s) begin
              rn_out_r <= rn_out_r | grp_bit_s;
              idx_r    <= idx_r + IDX_ONE;
            end else begin
              idx_r <= idx_r;
            end
          end
        end
        SETTLE: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= UNGATE;
            cken_r  <= '1;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        UNGATE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ASSERT;
          cnt_r    <= PULSE_LD;
          idx_r    <= '0;
          rn_out_r <= '0;
          cken_r   <= '0;
          busy_r   <= 1'b1;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rn_out = rn_out_r;
  assign bus.cken   = cken_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_rst_release_seq.sv
// Bench for rst_release_seq: a position-in-sequence model predicts every output
// each cycle; directed scenarios pin key edges with literal values.
module tb_rst_release_seq;
  localparam int NGRP = 4;
  localparam int W    = 3;
  localparam int P    = 2;
  localparam int S    = 2;
`ifdef RST_SEQ_STAGGER_EN
  localparam bit              STG     = 1'b1;
  localparam int              RL      = (NGRP - 1) * S + 1;
  localparam int              PO_DONE = 12;
  localparam int              ST_DONE = 15;
  localparam logic [NGRP-1:0] RN_E5   = 4'b0001;
  localparam logic [NGRP-1:0] RN_E9   = 4'b0111;
`else
  localparam bit              STG     = 1'b0;
  localparam int              RL      = 1;
  localparam int              PO_DONE = 6;
  localparam int              ST_DONE = 9;
  localparam logic [NGRP-1:0] RN_E5   = 4'b1111;
  localparam logic [NGRP-1:0] RN_E9   = 4'b1111;
`endif
  localparam int RS  = W + P;
  localparam int UNG = RS + RL + W;
  localparam int LAT = 2 * W + P + RL + 1;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  rst_release_seq_if #(.NGRP(NGRP)) bus ();

  rst_release_seq #(.NGRP(NGRP), .WAIT_CYC(W), .PULSE_CYC(P), .STAGGER(S)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 ck = ~ck;

  int tests  = 0;
  int fails  = 0;
  int pos    = -1;   // cycles since GATE entry; -1 means idle
  bit chk_en = 1'b0;
  int e_now  = 0;
  int age [NGRP];
  int dcount;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NGRP-1:0] exp_rn(input int p);
    logic [NGRP-1:0] v;
    v = '1;
    if (p >= W && p < RS) v = '0;
    else if (p >= RS && p < RS + RL)
      for (int k = 0; k < NGRP; k++) v[k] = STG ? ((p - RS) >= k * S) : 1'b1;
    return v;
  endfunction

  function automatic int next_pos(input int p, input logic r, input logic st);
    if (r) return W;
    if (p < 0) return st ? 0 : -1;
    if (p >= UNG) return -1;
    return p + 1;
  endfunction

  always @(posedge ck) pos <= next_pos(pos, rst, bus.start);

  // Per-cycle comparison against the model plus the reset/clock-enable margin invariant
  always @(negedge ck) begin
    if (chk_en) begin
      check("rn_out", 16'(bus.rn_out), 16'(exp_rn(pos)));
      check("cken", 16'(bus.cken), ((pos < 0) || (pos == UNG)) ? 16'hF : 16'h0);
      check("busy", 16'(bus.busy), 16'(pos >= 0));
      check("done", 16'(bus.done), 16'(pos == UNG));
      for (int k = 0; k < NGRP; k++) begin
        if (bus.cken[k]) begin
          check("inv_rn_high", 16'(bus.rn_out[k]), 16'd1);
          check("inv_margin", 16'(age[k] >= W), 16'd1);
        end
        age[k] = bus.rn_out[k] ? ((age[k] < 1000) ? age[k] + 1 : age[k]) : 0;
      end
    end
  end

  task automatic goto_edge(input int n);
    while (e_now < n) begin
      @(negedge ck);
      e_now++;
    end
  endtask

  initial begin
    for (int k = 0; k < NGRP; k++) age[k] = 0;
    bus.start = 1'b0;
    rst = 1'b1;
    // power-on: RST sampled high on three edges, the last is edge 0
    @(negedge ck);
    chk_en = 1'b1;
    check("rst_rn", 16'(bus.rn_out), 16'h0);
    check("rst_cken", 16'(bus.cken), 16'h0);
    check("rst_busy", 16'(bus.busy), 16'd1);
    @(negedge ck);
    @(negedge ck);
    rst = 1'b0;
    e_now = 0;
    goto_edge(1);
    check("po_rn_e1", 16'(bus.rn_out), 16'h0);
    goto_edge(2);
    check("po_rn0_e2", 16'(bus.rn_out[0]), 16'd1);
    goto_edge(PO_DONE);
    check("po_done", 16'(bus.done), 16'd1);
    check("po_cken", 16'(bus.cken), 16'hF);
    goto_edge(PO_DONE + 1);
    check("po_idle", 16'(bus.busy), 16'd0);

    // single START pulse sampled at edge 0
    goto_edge(PO_DONE + 3);
    bus.start = 1'b1;
    @(negedge ck);
    bus.start = 1'b0;
    e_now = 0;
    check("st_gate_cken", 16'(bus.cken), 16'h0);
    check("st_gate_busy", 16'(bus.busy), 16'd1);
    goto_edge(3);
    check("st_assert", 16'(bus.rn_out), 16'h0);
    goto_edge(5);
    check("st_rel_e5", 16'(bus.rn_out), 16'(RN_E5));
    goto_edge(ST_DONE - 1);
    check("st_all_rn", 16'(bus.rn_out), 16'hF);
    check("st_no_done", 16'(bus.done), 16'd0);
    goto_edge(ST_DONE);
    check("st_done", 16'(bus.done), 16'd1);
    goto_edge(ST_DONE + 1);
    check("st_done_drop", 16'(bus.done), 16'd0);
    check("st_idle", 16'(bus.busy), 16'd0);
    goto_edge(ST_DONE + 3);

    // START held: one DONE, restart only on the first IDLE cycle
    bus.start = 1'b1;
    @(negedge ck);
    dcount = int'(bus.done);
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge ck);
      dcount += int'(bus.done);
      if (e == LAT) check("held_idle", 16'(bus.busy), 16'd0);
    end
    check("held_restart", 16'(bus.busy), 16'd1);
    check("held_one_done", 16'(dcount), 16'd1);
    bus.start = 1'b0;
    repeat (LAT + 3) @(negedge ck);

    // RST in the middle of a sequence
    bus.start = 1'b1;
    @(negedge ck);
    bus.start = 1'b0;
    e_now = 0;
    goto_edge(9);
    check("mid_rn_e9", 16'(bus.rn_out), 16'(RN_E9));
    rst = 1'b1;
    goto_edge(10);
    rst = 1'b0;
    check("mid_rst_rn", 16'(bus.rn_out), 16'h0);
    check("mid_rst_cken", 16'(bus.cken), 16'h0);
    goto_edge(10 + P);
    check("mid_no_gate", 16'(bus.rn_out[0]), 16'd1);
    repeat (LAT + 3) @(negedge ck);

    // randomized START/RST traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge ck);
      rst = ($urandom_range(0, 99) < 3);
      bus.start = ($urandom_range(0, 3) == 0);
    end
    @(negedge ck);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (LAT + 5) @(negedge ck);
    check("final_idle", 16'(bus.busy), 16'd0);
    check("final_rn", 16'(bus.rn_out), 16'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
